// File: rtl/timer_button_ctrl.sv
// Five-channel button conditioner: 2-flop sync, debounce, one-cycle press pulses.
// Define TIMER_BTN_AUTOREPEAT_EN to add hold-to-repeat on the min/sec channels.
module timer_button_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_PERIOD   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_start,
  input  logic       btn_reset,
  input  logic       btn_clear,
  output logic       min_set_p,
  output logic       sec_set_p,
  output logic       start_stop_p,
  output logic       reset_p,
  output logic       clear_set_p,
  output logic [4:0] btn_level
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       btn_raw;
  logic [4:0]       s1;
  logic [4:0]       s2;
  logic [4:0]       stable;
  logic [4:0]       flip;
  logic [4:0]       rise;
  logic [4:0]       rep_fire;
  logic [4:0]       pulse;
  logic [CNT_W-1:0] cnt [5];

  assign btn_raw = {btn_clear, btn_reset, btn_start, btn_sec, btn_min};

  // A flip happens on the Nth consecutive cycle the synced input disagrees with stable.
  always_comb begin
    flip = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      flip[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise = flip & s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      pulse  <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1    <= btn_raw;
      s2    <= s1;
      pulse <= rise | rep_fire;
      for (int unsigned i = 0; i < 5; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef TIMER_BTN_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W  = $clog2(REP_MAX + 1);
  localparam logic [HOLD_W-1:0] DLY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PER_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {REP_IDLE, REP_DELAY, REP_PERIOD} rep_state_t;

  logic [1:0] fall;
  logic [1:0] rep_lo;

  assign fall     = flip[1:0] & ~s2[1:0];
  assign rep_fire = {3'b000, rep_lo};

  for (genvar g = 0; g < 2; g++) begin : g_rep
    rep_state_t        state;
    rep_state_t        state_nxt;
    logic [HOLD_W-1:0] hcnt;
    logic [HOLD_W-1:0] hcnt_nxt;
    logic              fire;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= REP_IDLE;
        hcnt  <= '0;
      end else begin
        state <= state_nxt;
        hcnt  <= hcnt_nxt;
      end
    end

    // The press pulse and entry into REP_DELAY share an edge, so hcnt counts from the pulse.
    always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      case (state)
        REP_IDLE: begin
          if (rise[g]) begin
            state_nxt = REP_DELAY;
            hcnt_nxt  = '0;
          end
        end
        REP_DELAY: begin
          if (fall[g]) begin
            state_nxt = REP_IDLE;
            hcnt_nxt  = '0;
          end else if (hcnt == DLY_LAST) begin
            state_nxt = REP_PERIOD;
            hcnt_nxt  = '0;
          end else begin
            hcnt_nxt = hcnt + 1'b1;
          end
        end
        REP_PERIOD: begin
          if (fall[g]) begin
            state_nxt = REP_IDLE;
            hcnt_nxt  = '0;
          end else if (hcnt == PER_LAST) begin
            hcnt_nxt = '0;
          end else begin
            hcnt_nxt = hcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = REP_IDLE;
          hcnt_nxt  = '0;
        end
      endcase
    end

    always_comb begin
      fire = 1'b0;
      if (!fall[g]) begin
        fire = ((state == REP_DELAY) && (hcnt == DLY_LAST)) ||
               ((state == REP_PERIOD) && (hcnt == PER_LAST));
      end
    end

    assign rep_lo[g] = fire;
  end
`else
  assign rep_fire = '0;
`endif

  assign min_set_p    = pulse[0];
  assign sec_set_p    = pulse[1];
  assign start_stop_p = pulse[2];
  assign reset_p      = pulse[3];
  assign clear_set_p  = pulse[4];
  assign btn_level    = stable;

endmodule

// File: tb/tb_timer_button_ctrl.sv
// Self-checking bench for timer_button_ctrl: vector table, directed sequences,
// and random stimulus against a window-based reference model.
module tb_timer_button_ctrl;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;
`ifdef TIMER_BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;
  logic       min_set_p, sec_set_p, start_stop_p, reset_p, clear_set_p;
  logic [4:0] btn_level;
  logic [4:0] dut_p;

  timer_button_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_min     (btn[0]),
    .btn_sec     (btn[1]),
    .btn_start   (btn[2]),
    .btn_reset   (btn[3]),
    .btn_clear   (btn[4]),
    .min_set_p   (min_set_p),
    .sec_set_p   (sec_set_p),
    .start_stop_p(start_stop_p),
    .reset_p     (reset_p),
    .clear_set_p (clear_set_p),
    .btn_level   (btn_level)
  );

  assign dut_p = {clear_set_p, reset_p, start_stop_p, sec_set_p, min_set_p};

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned n_edge = 0;

  // Reference model: raw samples per edge; level flips once the last D values the
  // debouncer saw (two edges behind the pins) all disagree with it.
  logic [D+1:0] m_hist [5];
  logic [4:0]   m_lvl = '0;
  logic [4:0]   exp_p = '0;
  int unsigned  m_press [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, n_edge, act, req);
    end
  endtask

  task automatic model_step();
    if (!rst) begin
      for (int ch = 0; ch < 5; ch++) m_hist[ch] = '0;
      m_lvl = '0;
      exp_p = '0;
    end else begin
      for (int ch = 0; ch < 5; ch++) begin
        logic [D-1:0] win;
        int unsigned  age;
        m_hist[ch] = {m_hist[ch][D:0], btn[ch]};
        win        = m_hist[ch][D+1:2];
        exp_p[ch]  = 1'b0;
        if (!m_lvl[ch] && (&win)) begin
          m_lvl[ch]   = 1'b1;
          exp_p[ch]   = 1'b1;
          m_press[ch] = n_edge;
        end else if (m_lvl[ch] && !(|win)) begin
          m_lvl[ch] = 1'b0;
        end else if (REP_EN && ch < 2 && m_lvl[ch]) begin
          age = n_edge - m_press[ch];
          if (age >= RD && ((age - RD) % RP) == 0) exp_p[ch] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick(input logic [4:0] raw);
    btn = raw;
    @(posedge clk);
    n_edge++;
    #1;
    model_step();
    check("model", {54'd0, dut_p, btn_level}, {54'd0, exp_p, m_lvl});
  endtask

  typedef struct {
    logic [4:0] raw;
    int         n;
    logic [4:0] exp_p;
    logic [4:0] exp_lvl;
  } vec_t;

  vec_t        tbl [$];
  logic [63:0] obs_mask;
  logic [63:0] exp_mask;
  logic [4:0]  cur;

  initial begin
    for (int ch = 0; ch < 5; ch++) begin
      m_hist[ch]  = '0;
      m_press[ch] = 0;
    end

    // Reset held with every button pressed
    btn = '1;
    #1 rst = 1'b0;
    #22;
    check("reset_hold", {54'd0, dut_p, btn_level}, 64'd0);
    for (int i = 0; i < 3; i++) tick('1);
    rst = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick('1);
      if (e < 6) check("rst_rel_quiet", {59'd0, dut_p}, 64'd0);
      else       check("rst_rel_pulse", {59'd0, dut_p}, 64'h1f);
    end
    for (int i = 0; i < 10; i++) tick('0);

    // Vector table: {raw, cycles, pulses, levels} checked after the last cycle
    tbl.push_back('{5'b00100, 5, 5'b00000, 5'b00000});
    tbl.push_back('{5'b00100, 1, 5'b00100, 5'b00100});
    tbl.push_back('{5'b00100, 3, 5'b00000, 5'b00100});
    tbl.push_back('{5'b00000, 5, 5'b00000, 5'b00100});
    tbl.push_back('{5'b00000, 1, 5'b00000, 5'b00000});
    tbl.push_back('{5'b01000, 3, 5'b00000, 5'b00000});
    tbl.push_back('{5'b00000, 6, 5'b00000, 5'b00000});
    tbl.push_back('{5'b01000, 2, 5'b00000, 5'b00000});
    tbl.push_back('{5'b00000, 1, 5'b00000, 5'b00000});
    tbl.push_back('{5'b01000, 5, 5'b00000, 5'b00000});
    tbl.push_back('{5'b01000, 1, 5'b01000, 5'b01000});
    tbl.push_back('{5'b01000, 4, 5'b00000, 5'b01000});
    tbl.push_back('{5'b00000, 5, 5'b00000, 5'b01000});
    tbl.push_back('{5'b00000, 1, 5'b00000, 5'b00000});
    tbl.push_back('{5'b10001, 5, 5'b00000, 5'b00000});
    tbl.push_back('{5'b10001, 1, 5'b10001, 5'b10001});
    tbl.push_back('{5'b10001, 2, 5'b00000, 5'b10001});
    tbl.push_back('{5'b00000, 5, 5'b00000, 5'b10001});
    tbl.push_back('{5'b00000, 1, 5'b00000, 5'b00000});
    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].raw);
      check($sformatf("tbl%0d", i), {54'd0, dut_p, btn_level}, {54'd0, tbl[i].exp_p, tbl[i].exp_lvl});
    end
    for (int i = 0; i < 4; i++) tick('0);

    // Hold sec for 30 cycles and record every edge carrying sec_set_p
    obs_mask = '0;
    exp_mask = '0;
    exp_mask[6] = 1'b1;
    if (REP_EN) for (int k = 16; k <= 34; k += 3) exp_mask[k] = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      tick((e <= 30) ? 5'b00010 : 5'b00000);
      if (sec_set_p) obs_mask[e] = 1'b1;
    end
    check("autorepeat_edges", obs_mask, exp_mask);

    // Reset asserted just after edge 17 of a held sec press
    for (int e = 1; e <= 17; e++) tick(5'b00010);
    rst = 1'b0;
    #1;
    check("midhold_async", {54'd0, dut_p, btn_level}, 64'd0);
    tick(5'b00010);
    tick(5'b00010);
    check("midhold_edge19", {63'd0, sec_set_p}, 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) tick(5'b00010);
    for (int i = 0; i < 10; i++) tick('0);

    // Random slow-changing buttons with occasional resets
    cur = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
      if ($urandom_range(0, 149) == 0) rst = 1'b0;
      tick(cur);
      rst = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
